// File: rtl/stream_capture_if.sv
// Bundles the capture stage's control, serial input, readback and status signals.
// Clock and reset stay as plain ports on the module.
interface stream_capture_if;
    logic       start;
    logic       serial_in;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [4:0] byte_count;
    logic       busy;
    logic       full;

    modport master (
        output start, serial_in, rd_addr,
        input  rd_data, byte_out, byte_valid, byte_count, busy, full
    );

    modport slave (
        input  start, serial_in, rd_addr,
        output rd_data, byte_out, byte_valid, byte_count, busy, full
    );
endinterface

// File: rtl/stream_capture.sv
// Deserialises an MSB-first bit stream into bytes and keeps the first 16 in a readable buffer.
// Latency: byte_out/byte_valid/byte_count update on the 8th sample edge; rd_data is combinational.
// Backpressure: none; the stream is sampled unconditionally, and capture stops once the buffer is full.
module stream_capture #(
    parameter int BIT_DIV = 1,
    parameter int DEPTH   = 16
) (
    input  logic              sysclk,
    input  logic              rst_n,
    stream_capture_if.slave   cap
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [4:0] LAST_IDX = 5'(DEPTH - 1);

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic [4:0] byte_count_q, byte_count_d;

    logic [7:0] mem_q [DEPTH];
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_dat;

    logic [7:0] next_byte;
    logic       sample;

    assign next_byte = {shift_q, cap.serial_in};
    assign sample    = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        byte_count_d = byte_count_q;
        wr_en        = 1'b0;
        wr_addr      = byte_count_q[3:0];
        wr_dat       = next_byte;

        case (state_q)
            IDLE: begin
                div_cnt_d    = 8'd0;
                bit_idx_d    = 3'd0;
                byte_count_d = 5'd0;
                if (cap.start) begin
                    shift_d = 7'd0;
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                // A restart overrides everything, including a byte that would complete now.
                if (cap.start) begin
                    div_cnt_d    = 8'd0;
                    bit_idx_d    = 3'd0;
                    byte_count_d = 5'd0;
                    shift_d      = 7'd0;
                end else if (sample) begin
                    div_cnt_d = 8'd0;
                    shift_d   = next_byte[6:0];
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        byte_out_d   = next_byte;
                        byte_valid_d = 1'b1;
                        wr_en        = 1'b1;
                        byte_count_d = byte_count_q + 5'd1;
                        if (byte_count_q == LAST_IDX) begin
                            state_d = DONE;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            DONE: begin
                if (cap.start) begin
                    div_cnt_d    = 8'd0;
                    bit_idx_d    = 3'd0;
                    byte_count_d = 5'd0;
                    shift_d      = 7'd0;
                    state_d      = CAPTURE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= 8'd0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_out_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_count_q <= 5'd0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_count_q <= byte_count_d;
        end
    end

    // Buffer contents survive reset; the count gate on the read path hides stale entries.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign cap.rd_data    = ({1'b0, cap.rd_addr} < byte_count_q) ? mem_q[cap.rd_addr] : 8'h00;
    assign cap.byte_out   = byte_out_q;
    assign cap.byte_valid = byte_valid_q;
    assign cap.byte_count = byte_count_q;
    assign cap.busy       = (state_q == CAPTURE);
    assign cap.full       = (state_q == DONE);

endmodule

// File: tb/tb_stream_capture.sv
// Randomised scoreboard bench for stream_capture: a byte-level model predicts every byte_valid,
// buffer readback and status flag for a BIT_DIV=1 instance and a BIT_DIV=4 instance.
module tb_stream_capture;
    timeunit 1ns;
    timeprecision 100ps;

    typedef struct packed {
        logic [7:0] b;
        logic [4:0] c;
    } exp_t;

    logic sysclk;
    logic rst_n;

    stream_capture_if if1 ();
    stream_capture_if if4 ();

    stream_capture #(.BIT_DIV(1), .DEPTH(16)) u_dut1 (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .cap    (if1)
    );

    stream_capture #(.BIT_DIV(4), .DEPTH(16)) u_dut4 (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .cap    (if4)
    );

    int errors = 0;
    int checks = 0;

    exp_t       exp1 [$];
    exp_t       exp4 [$];
    logic [7:0] cap1 [$];

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: every byte_valid pulse must match the oldest predicted byte.
    always @(negedge sysclk) begin
        if (rst_n && if1.byte_valid) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_byte: got byte_out 0x%0h, none expected at %0t",
                         if1.byte_out, $time);
            end else begin
                exp_t e;
                e = exp1.pop_front();
                chk("dut1_byte_out", if1.byte_out, e.b);
                chk("dut1_byte_count", if1.byte_count, e.c);
            end
        end
    end

    always @(negedge sysclk) begin
        if (rst_n && if4.byte_valid) begin
            if (exp4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_byte: got byte_out 0x%0h, none expected at %0t",
                         if4.byte_out, $time);
            end else begin
                exp_t e;
                e = exp4.pop_front();
                chk("dut4_byte_out", if4.byte_out, e.b);
                chk("dut4_byte_count", if4.byte_count, e.c);
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_start1();
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        cap1.delete();
    endtask

    // Sends a whole byte; the model captures it only while fewer than 16 are held.
    task automatic send_byte1(input logic [7:0] b);
        if (cap1.size() < 16) begin
            exp_t e;
            cap1.push_back(b);
            e.b = b;
            e.c = 5'(cap1.size());
            exp1.push_back(e);
        end
        for (int i = 7; i >= 0; i--) begin
            if1.serial_in = b[i];
            tick();
        end
    endtask

    task automatic send_raw1(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if1.serial_in = b[7-i];
            tick();
        end
    endtask

    // All reads happen inside one clock low/high phase, so no sample edge intervenes.
    task automatic read_all1(input string name);
        for (int a = 0; a < 16; a++) begin
            logic [7:0] req;
            if1.rd_addr = 4'(a);
            #0.2;
            req = (a < cap1.size()) ? cap1[a] : 8'h00;
            chk(name, if1.rd_data, req);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_byte_out"},   if1.byte_out,   8'h00);
        chk({name, "_byte_valid"}, if1.byte_valid, 1'b0);
        chk({name, "_byte_count"}, if1.byte_count, 5'd0);
        chk({name, "_busy"},       if1.busy,       1'b0);
        chk({name, "_full"},       if1.full,       1'b0);
        chk({name, "_rd_data"},    if1.rd_data,    8'h00);
    endtask

    initial begin
        logic [7:0] pat;
        int first_vld;

        rst_n = 1'b0;
        if1.start = 1'b0; if1.serial_in = 1'b0; if1.rd_addr = 4'd0;
        if4.start = 1'b0; if4.serial_in = 1'b0; if4.rd_addr = 4'd0;
        repeat (3) tick();
        check_idle_outputs("reset");
        chk("reset_dut4_count", if4.byte_count, 5'd0);
        chk("reset_dut4_busy", if4.busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // BIT_DIV=4: each bit held 4 cycles, byte_valid after the 32nd CAPTURE cycle.
        pat = 8'h3C;
        exp4.push_back('{b: 8'h3C, c: 5'd1});
        if4.start = 1'b1;
        tick();
        if4.start = 1'b0;
        chk("dut4_busy_after_start", if4.busy, 1'b1);
        first_vld = 0;
        for (int i = 1; i <= 40; i++) begin
            if4.serial_in = (i <= 32) ? pat[7 - (i - 1) / 4] : 1'b0;
            tick();
            if (if4.byte_valid && first_vld == 0) first_vld = i;
        end
        chk("dut4_valid_cycle", 32'(first_vld), 32'd32);
        if4.rd_addr = 4'd0;
        #0.2;
        chk("dut4_rd0", if4.rd_data, 8'h3C);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check_idle_outputs("reset2");

        // 0xA5 at BIT_DIV=1, then readback of entries 0 and 1.
        pulse_start1();
        send_byte1(8'hA5);
        chk("a5_byte_count", if1.byte_count, 5'd1);
        if1.rd_addr = 4'd0;
        #0.2;
        chk("a5_rd0", if1.rd_data, 8'hA5);
        if1.rd_addr = 4'd1;
        #0.2;
        chk("a5_rd1", if1.rd_data, 8'h00);

        // Start coinciding with a byte-completing sample wins.
        pulse_start1();
        send_raw1(8'hFF, 7);
        if1.serial_in = 1'b1;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        cap1.delete();
        chk("collide_no_valid", if1.byte_valid, 1'b0);
        chk("collide_count", if1.byte_count, 5'd0);

        // Partial byte discarded by a restart.
        send_raw1(8'hA0, 3);
        pulse_start1();
        send_byte1(8'hFF);
        chk("partial_count", if1.byte_count, 5'd1);
        read_all1("partial_rd");

        // Fill all 16 entries, then keep toggling: nothing more is captured.
        pulse_start1();
        for (int i = 0; i < 16; i++) send_byte1(8'(i));
        chk("fill_full", if1.full, 1'b1);
        chk("fill_busy", if1.busy, 1'b0);
        chk("fill_count", if1.byte_count, 5'd16);
        send_byte1(8'h55);
        send_byte1(8'hAA);
        chk("fill_count_after", if1.byte_count, 5'd16);
        read_all1("fill_rd");

        // Restart from DONE.
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        cap1.delete();
        chk("redo_full", if1.full, 1'b0);
        chk("redo_busy", if1.busy, 1'b1);
        chk("redo_count", if1.byte_count, 5'd0);
        send_byte1(8'h81);
        read_all1("redo_rd");

        // Randomised capture rounds.
        for (int r = 0; r < 5; r++) begin
            int n;
            if (cap1.size() == 16) send_raw1(8'($urandom), 8);
            pulse_start1();
            n = $urandom_range(1, 20);
            for (int k = 0; k < n; k++) send_byte1(8'($urandom));
            chk("rand_count", if1.byte_count, 5'(cap1.size()));
            chk("rand_full", if1.full, (cap1.size() == 16) ? 1'b1 : 1'b0);
            read_all1("rand_rd");
        end

        // Asynchronous reset in the middle of the third byte.
        pulse_start1();
        send_byte1(8'h12);
        send_byte1(8'h34);
        send_raw1(8'hF0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        cap1.delete();
        check_idle_outputs("midreset");
        tick();
        rst_n = 1'b1;
        send_raw1(8'hFF, 8);
        chk("post_reset_idle_busy", if1.busy, 1'b0);
        chk("post_reset_idle_count", if1.byte_count, 5'd0);
        pulse_start1();
        send_byte1(8'h5A);
        read_all1("post_reset_rd");

        tick();
        chk("dut1_pending_bytes", 32'(exp1.size()), 32'd0);
        chk("dut4_pending_bytes", 32'(exp4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
